// File: rtl/ram_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bus_pkg
//  Description : Shared types and constants for the two-master RAM front end.
//                Holds the grant/arbiter-state encodings, the RAM depth and
//                the default byte base address of the RAM window.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_bus_pkg;

    // RAM geometry: 4096 words of 32 bits.
    localparam int          RAM_AW            = 12;
    localparam int          RAM_WORDS         = 1 << RAM_AW;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    // Which master owns a transfer (used for response routing).
    typedef enum logic [0:0] {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // Round-robin arbiter state: the master granted most recently.
    typedef enum logic [0:0] {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } arb_state_t;

endpackage : ram_bus_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. The grant is combinational in
//                the request cycle; the last-grant state register advances on
//                every grant. Under contention the master that was NOT granted
//                last wins, so continuous contention alternates strictly.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk    in   clock
//    rst    in   synchronous active-high reset (forces no grant, state LAST_I)
//    req_i  in   instruction-bus request
//    req_d  in   data-bus request
//    gnt_i  out  instruction-bus grant (combinational)
//    gnt_d  out  data-bus grant (combinational)
//    state  out  current last-grant state
// ============================================================================
module rr_arb2
    import ram_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    output logic       gnt_i,
    output logic       gnt_d,
    output arb_state_t state
);

    arb_state_t r_last;

    // No grant is issued while reset is asserted, so nothing reaches the RAM.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (req_i && req_d) begin
                gnt_d = (r_last == LAST_I);
                gnt_i = (r_last == LAST_D);
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= LAST_I;
        end else if (gnt_i) begin
            r_last <= LAST_I;
        end else if (gnt_d) begin
            r_last <= LAST_D;
        end
    end

    assign state = r_last;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bus_bridge
//  Description : Front end for the 4096x32 synchronous on-chip RAM. Arbitrates
//                the instruction-fetch bus and the data bus onto the single
//                RAM port, decodes the address window, drives the RAM pins and
//                routes the one-cycle-late read data back to the requester.
//  Revision    : 1.0  initial release
//
//  Ports:
//    CLK, RST                      clock, synchronous active-high reset
//    ib_cmd_valid/ready/addr       fetch command handshake and byte address
//    ib_rsp_valid/data             fetch response (one cycle after accept)
//    db_cmd_valid/ready/wr/addr    data command handshake, direction, address
//    db_cmd_data/mask              write data and byte-lane enables
//    db_rsp_valid/data             data read response (reads only)
//    oor_pulse                     pulse the cycle after an out-of-window accept
//    RAM_ADR/D/WEM/WE/ME/OE        RAM macro control and write-data pins
//    RAM_Q                         RAM read data (valid the cycle after ME)
// ============================================================================
module ram_bus_bridge
    import ram_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = RAM_AW,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic                  CLK,
    input  logic                  RST,
    // instruction-fetch bus
    input  logic                  ib_cmd_valid,
    output logic                  ib_cmd_ready,
    input  logic [31:0]           ib_cmd_addr,
    output logic                  ib_rsp_valid,
    output logic [31:0]           ib_rsp_data,
    // data bus
    input  logic                  db_cmd_valid,
    output logic                  db_cmd_ready,
    input  logic                  db_cmd_wr,
    input  logic [31:0]           db_cmd_addr,
    input  logic [31:0]           db_cmd_data,
    input  logic [3:0]            db_cmd_mask,
    output logic                  db_rsp_valid,
    output logic [31:0]           db_rsp_data,
    // status
    output logic                  oor_pulse,
    // RAM macro
    output logic [ADDR_WIDTH-1:0] RAM_ADR,
    output logic [31:0]           RAM_D,
    output logic [3:0]            RAM_WEM,
    output logic                  RAM_WE,
    output logic                  RAM_ME,
    output logic                  RAM_OE,
    input  logic [31:0]           RAM_Q
);

    // Address bits above the word index select the window.
    localparam int WIN_LSB = ADDR_WIDTH + 2;

    logic                  w_gnt_i;
    logic                  w_gnt_d;
    logic                  w_any_gnt;
    logic [31:0]           w_addr;
    logic                  w_in_range;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    arb_state_t            w_arb_state;
    logic                  w_unused;

    logic [ADDR_WIDTH-1:0] r_adr;
    logic [31:0]           r_d;
    logic                  r_pend;
    gnt_t                  r_who;
    logic                  r_oor;
    logic                  r_oor_pulse;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req_i (ib_cmd_valid),
        .req_d (db_cmd_valid),
        .gnt_i (w_gnt_i),
        .gnt_d (w_gnt_d),
        .state (w_arb_state)
    );

    assign ib_cmd_ready = w_gnt_i;
    assign db_cmd_ready = w_gnt_d;
    assign w_any_gnt    = w_gnt_i | w_gnt_d;

    // Address of whichever master holds the grant this cycle.
    assign w_addr      = w_gnt_d ? db_cmd_addr : ib_cmd_addr;
    assign w_in_range  = (w_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign w_word_addr = w_addr[WIN_LSB-1:2];

    // Every iBus command is a read; dBus commands are reads when wr = 0.
    assign w_rd_accept = w_gnt_i | (w_gnt_d & ~db_cmd_wr);

    // RAM pins. ADR/D follow the granted command in its own cycle because the
    // RAM samples them on the same edge; otherwise they hold the last value.
    assign RAM_ME  = w_any_gnt & w_in_range;
    assign RAM_WE  = w_gnt_d & db_cmd_wr & w_in_range;
    assign RAM_WEM = RAM_WE ? db_cmd_mask : 4'b0000;
    assign RAM_ADR = w_any_gnt ? w_word_addr : r_adr;
    assign RAM_D   = w_any_gnt ? db_cmd_data : r_d;
    assign RAM_OE  = 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_adr       <= '0;
            r_d         <= '0;
            r_pend      <= 1'b0;
            r_who       <= GNT_I;
            r_oor       <= 1'b0;
            r_oor_pulse <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_adr <= w_word_addr;
                r_d   <= db_cmd_data;
            end
            // Response pipeline stage: loaded on every accepted read, cleared
            // on any other cycle.
            r_pend      <= w_rd_accept;
            r_who       <= w_gnt_d ? GNT_D : GNT_I;
            r_oor       <= w_rd_accept & ~w_in_range;
            r_oor_pulse <= w_any_gnt & ~w_in_range;
        end
    end

    // A read accepted just before reset rises must not respond, so the
    // pending flag is masked by the reset cycle itself.
    assign ib_rsp_valid = r_pend & ~RST & (r_who == GNT_I);
    assign db_rsp_valid = r_pend & ~RST & (r_who == GNT_D);
    assign ib_rsp_data  = r_oor ? 32'h0000_0000 : RAM_Q;
    assign db_rsp_data  = r_oor ? 32'h0000_0000 : RAM_Q;
    assign oor_pulse    = r_oor_pulse;

    // Byte-offset bits are ignored; the arbiter state is exported only for
    // observation.
    assign w_unused = ^{w_addr[1:0], w_arb_state};

endmodule : ram_bus_bridge
`default_nettype wire

// File: tb/tb_ram_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_bus_bridge
//  Description : Self-checking bench for ram_bus_bridge. A behavioural RAM
//                macro sits behind the DUT; a shadow memory and per-master
//                expectation queues form the scoreboard for responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_bus_bridge;

    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ib_cmd_valid = 1'b0;
    logic          ib_cmd_ready;
    logic [31:0]   ib_cmd_addr = '0;
    logic          ib_rsp_valid;
    logic [31:0]   ib_rsp_data;
    logic          db_cmd_valid = 1'b0;
    logic          db_cmd_ready;
    logic          db_cmd_wr = 1'b0;
    logic [31:0]   db_cmd_addr = '0;
    logic [31:0]   db_cmd_data = '0;
    logic [3:0]    db_cmd_mask = '0;
    logic          db_rsp_valid;
    logic [31:0]   db_rsp_data;
    logic          oor_pulse;
    logic [AW-1:0] RAM_ADR;
    logic [31:0]   RAM_D;
    logic [3:0]    RAM_WEM;
    logic          RAM_WE;
    logic          RAM_ME;
    logic          RAM_OE;
    logic [31:0]   RAM_Q;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        qi[$];
    exp_t        qd[$];
    logic        exp_oor = 1'b0;
    logic [31:0] ram_mem [0:(1<<AW)-1];
    logic [31:0] sh_mem  [0:(1<<AW)-1];
    logic [31:0] ram_q_r = '0;

    ram_bus_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ib_cmd_valid (ib_cmd_valid),
        .ib_cmd_ready (ib_cmd_ready),
        .ib_cmd_addr  (ib_cmd_addr),
        .ib_rsp_valid (ib_rsp_valid),
        .ib_rsp_data  (ib_rsp_data),
        .db_cmd_valid (db_cmd_valid),
        .db_cmd_ready (db_cmd_ready),
        .db_cmd_wr    (db_cmd_wr),
        .db_cmd_addr  (db_cmd_addr),
        .db_cmd_data  (db_cmd_data),
        .db_cmd_mask  (db_cmd_mask),
        .db_rsp_valid (db_rsp_valid),
        .db_rsp_data  (db_rsp_data),
        .oor_pulse    (oor_pulse),
        .RAM_ADR      (RAM_ADR),
        .RAM_D        (RAM_D),
        .RAM_WEM      (RAM_WEM),
        .RAM_WE       (RAM_WE),
        .RAM_ME       (RAM_ME),
        .RAM_OE       (RAM_OE),
        .RAM_Q        (RAM_Q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        return {16'hC0DE, i[15:0]};
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a[31:AW+2] == '0);
    endfunction

    // Behavioural synchronous RAM macro.
    always @(posedge CLK) begin
        if (RAM_ME) begin
            if (RAM_WE) begin
                for (int b = 0; b < 4; b++)
                    if (RAM_WEM[b]) ram_mem[RAM_ADR][b*8 +: 8] <= RAM_D[b*8 +: 8];
            end
            ram_q_r <= ram_mem[RAM_ADR];
        end
    end
    assign RAM_Q = ram_q_r;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: responses are checked against queued expectations, then
    // this cycle's accepted commands queue their own expectations.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            total++;
            if (ib_rsp_valid !== 1'b0 || db_rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rsp_in_reset: ib_rsp_valid=%b db_rsp_valid=%b required 0/0", ib_rsp_valid, db_rsp_valid);
            end
            qi.delete();
            qd.delete();
            exp_oor = 1'b0;
        end else begin
            if (ib_rsp_valid === 1'b1) begin
                total++;
                if (qi.size() == 0 || qi[0].due != cyc) begin
                    bad++;
                    $display("FAIL ib_rsp_unexpected: cycle %0d got data %h with no response due", cyc, ib_rsp_data);
                end else begin
                    e = qi.pop_front();
                    if (ib_rsp_data !== e.data) begin
                        bad++;
                        $display("FAIL ib_rsp_data: got %h required %h", ib_rsp_data, e.data);
                    end
                end
            end else if (qi.size() > 0 && qi[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL ib_rsp_missing: cycle %0d rsp_valid=%b required 1", cyc, ib_rsp_valid);
                void'(qi.pop_front());
            end

            if (db_rsp_valid === 1'b1) begin
                total++;
                if (qd.size() == 0 || qd[0].due != cyc) begin
                    bad++;
                    $display("FAIL db_rsp_unexpected: cycle %0d got data %h with no response due", cyc, db_rsp_data);
                end else begin
                    e = qd.pop_front();
                    if (db_rsp_data !== e.data) begin
                        bad++;
                        $display("FAIL db_rsp_data: got %h required %h", db_rsp_data, e.data);
                    end
                end
            end else if (qd.size() > 0 && qd[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL db_rsp_missing: cycle %0d rsp_valid=%b required 1", cyc, db_rsp_valid);
                void'(qd.pop_front());
            end

            total++;
            if (oor_pulse !== exp_oor) begin
                bad++;
                $display("FAIL oor_pulse: got %b required %b", oor_pulse, exp_oor);
            end

            if (ib_cmd_ready === 1'b1 && db_cmd_ready === 1'b1) begin
                total++;
                bad++;
                $display("FAIL dual_grant: both ready high at cycle %0d", cyc);
            end

            exp_oor = 1'b0;
            if (ib_cmd_valid && ib_cmd_ready === 1'b1) begin
                e.data = in_win(ib_cmd_addr) ? sh_mem[ib_cmd_addr[AW+1:2]] : 32'h0;
                e.due  = cyc + 1;
                qi.push_back(e);
                exp_oor = !in_win(ib_cmd_addr);
            end
            if (db_cmd_valid && db_cmd_ready === 1'b1) begin
                exp_oor = !in_win(db_cmd_addr);
                if (db_cmd_wr) begin
                    if (in_win(db_cmd_addr))
                        for (int b = 0; b < 4; b++)
                            if (db_cmd_mask[b])
                                sh_mem[db_cmd_addr[AW+1:2]][b*8 +: 8] = db_cmd_data[b*8 +: 8];
                end else begin
                    e.data = in_win(db_cmd_addr) ? sh_mem[db_cmd_addr[AW+1:2]] : 32'h0;
                    e.due  = cyc + 1;
                    qd.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ib_cmd_valid = 1'b0;
        db_cmd_valid = 1'b0;
        db_cmd_wr    = 1'b0;
    endtask

    task automatic drive_ib(input logic [31:0] a);
        ib_cmd_valid = 1'b1;
        ib_cmd_addr  = a;
    endtask

    task automatic drive_db(input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        db_cmd_valid = 1'b1;
        db_cmd_wr    = wr;
        db_cmd_addr  = a;
        db_cmd_data  = d;
        db_cmd_mask  = m;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive_ib(32'h40);
        drive_db(1'b0, 32'h80, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++;
            if (ib_cmd_ready !== 1'b0 || db_cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready: ib=%b db=%b required 0/0", ib_cmd_ready, db_cmd_ready);
            end
            total++;
            if (RAM_ME !== 1'b0 || RAM_WE !== 1'b0 || RAM_WEM !== 4'h0) begin
                bad++;
                $display("FAIL reset_ram_ctrl: ME=%b WE=%b WEM=%h required 0/0/0", RAM_ME, RAM_WE, RAM_WEM);
            end
            tick();
        end
        RST = 1'b0;
        idle();
        @(negedge CLK);
        total++;
        if (RAM_ADR !== '0 || RAM_D !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold_regs: ADR=%h D=%h required 0/0", RAM_ADR, RAM_D);
        end
        total++;
        if (ib_rsp_valid !== 1'b0 || db_rsp_valid !== 1'b0 || oor_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ib_rsp=%b db_rsp=%b oor=%b required 0/0/0", ib_rsp_valid, db_rsp_valid, oor_pulse);
        end
        tick();
        drive_ib(32'h40);
        drive_db(1'b0, 32'h80, 32'h0, 4'h0);
        @(negedge CLK);
        total++;
        if (db_cmd_ready !== 1'b1 || ib_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant: db=%b ib=%b required 1/0", db_cmd_ready, ib_cmd_ready);
        end
        tick();
        db_cmd_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (ib_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_second_grant: ib=%b required 1", ib_cmd_ready);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive_ib(32'(4 * k));
            else       idle();
            @(negedge CLK);
            if (k < 3) begin
                total++;
                if (ib_cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready[%0d]: got %b required 1", k, ib_cmd_ready);
                end
            end
            if (k >= 1 && k <= 3) begin
                total++;
                if (ib_rsp_valid !== 1'b1 || ib_rsp_data !== init_word(k - 1)) begin
                    bad++;
                    $display("FAIL b2b_rsp[%0d]: valid=%b data=%h required 1/%h", k, ib_rsp_valid, ib_rsp_data, init_word(k - 1));
                end
            end
            if (k == 4) begin
                total++;
                if (ib_rsp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_tail: ib_rsp_valid=%b required 0", ib_rsp_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        int   ii = 0;
        int   di = 0;
        logic exp_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_ib(32'h100 + 32'(4 * ii));
            drive_db(1'b0, 32'h200 + 32'(4 * di), 32'h0, 4'h0);
            @(negedge CLK);
            total++;
            if (db_cmd_ready !== exp_d || ib_cmd_ready !== !exp_d) begin
                bad++;
                $display("FAIL contention_grant[%0d]: db=%b ib=%b required %b/%b", k, db_cmd_ready, ib_cmd_ready, exp_d, !exp_d);
            end
            if (db_cmd_ready === 1'b1) di++;
            if (ib_cmd_ready === 1'b1) ii++;
            exp_d = !exp_d;
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_write_read();
        drive_db(1'b1, 32'h10, 32'h1111_1111, 4'hF);
        @(negedge CLK);
        total++;
        if (db_cmd_ready !== 1'b1 || RAM_ME !== 1'b1 || RAM_WE !== 1'b1 || RAM_WEM !== 4'hF
            || RAM_ADR !== 12'h004 || RAM_D !== 32'h1111_1111) begin
            bad++;
            $display("FAIL wr_full_pins: rdy=%b ME=%b WE=%b WEM=%h ADR=%h D=%h required 1/1/1/f/004/11111111",
                     db_cmd_ready, RAM_ME, RAM_WE, RAM_WEM, RAM_ADR, RAM_D);
        end
        tick();
        drive_db(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0101);
        @(negedge CLK);
        total++;
        if (RAM_WE !== 1'b1 || RAM_WEM !== 4'b0101) begin
            bad++;
            $display("FAIL wr_mask_pins: WE=%b WEM=%h required 1/5", RAM_WE, RAM_WEM);
        end
        total++;
        if (db_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_rsp: db_rsp_valid=%b required 0", db_rsp_valid);
        end
        tick();
        drive_db(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge CLK);
        total++;
        if (RAM_ME !== 1'b1 || RAM_WE !== 1'b0 || RAM_WEM !== 4'h0) begin
            bad++;
            $display("FAIL rd_pins: ME=%b WE=%b WEM=%h required 1/0/0", RAM_ME, RAM_WE, RAM_WEM);
        end
        tick();
        idle();
        @(negedge CLK);
        total++;
        if (db_rsp_valid !== 1'b1 || db_rsp_data !== 32'h11AD_11EF || ib_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_data: valid=%b data=%h ib_valid=%b required 1/11ad11ef/0", db_rsp_valid, db_rsp_data, ib_rsp_valid);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        drive_db(1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF);
        @(negedge CLK);
        total++;
        if (db_cmd_ready !== 1'b1 || RAM_ME !== 1'b0 || RAM_WE !== 1'b0) begin
            bad++;
            $display("FAIL oor_wr_pins: rdy=%b ME=%b WE=%b required 1/0/0", db_cmd_ready, RAM_ME, RAM_WE);
        end
        tick();
        drive_db(1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge CLK);
        total++;
        if (oor_pulse !== 1'b1 || RAM_ME !== 1'b1) begin
            bad++;
            $display("FAIL oor_wr_pulse: oor=%b ME=%b required 1/1", oor_pulse, RAM_ME);
        end
        tick();
        idle();
        drive_ib(32'h8000_0000);
        @(negedge CLK);
        total++;
        if (db_rsp_valid !== 1'b1 || db_rsp_data !== init_word(0)) begin
            bad++;
            $display("FAIL oor_mem_unchanged: valid=%b data=%h required 1/%h", db_rsp_valid, db_rsp_data, init_word(0));
        end
        total++;
        if (ib_cmd_ready !== 1'b1 || RAM_ME !== 1'b0 || oor_pulse !== 1'b0) begin
            bad++;
            $display("FAIL oor_rd_pins: rdy=%b ME=%b oor=%b required 1/0/0", ib_cmd_ready, RAM_ME, oor_pulse);
        end
        tick();
        idle();
        @(negedge CLK);
        total++;
        if (ib_rsp_valid !== 1'b1 || ib_rsp_data !== 32'h0 || oor_pulse !== 1'b1) begin
            bad++;
            $display("FAIL oor_rd_rsp: valid=%b data=%h oor=%b required 1/00000000/1", ib_rsp_valid, ib_rsp_data, oor_pulse);
        end
        tick();
    endtask

    task automatic test_reset_cancel();
        drive_db(1'b0, 32'h8, 32'h0, 4'h0);
        @(negedge CLK);
        total++;
        if (db_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cancel_accept: db_cmd_ready=%b required 1", db_cmd_ready);
        end
        tick();
        idle();
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (db_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL cancel_rsp_during_rst: db_rsp_valid=%b required 0", db_rsp_valid);
        end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (db_rsp_valid !== 1'b0 || ib_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL cancel_rsp_after_rst: db=%b ib=%b required 0/0", db_rsp_valid, ib_rsp_valid);
        end
        tick();
        drive_ib(32'h20);
        drive_db(1'b0, 32'h24, 32'h0, 4'h0);
        @(negedge CLK);
        total++;
        if (db_cmd_ready !== 1'b1 || ib_cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL cancel_arb_state: db=%b ib=%b required 1/0", db_cmd_ready, ib_cmd_ready);
        end
        tick();
        db_cmd_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (ib_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cancel_second_grant: ib=%b required 1", ib_cmd_ready);
        end
        tick();
        idle();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = init_word(i);
            sh_mem[i]  = init_word(i);
        end
        test_reset();
        test_back_to_back();
        test_contention();
        test_write_read();
        test_out_of_range();
        test_reset_cancel();
        total++;
        if (qi.size() != 0 || qd.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations: ib=%0d db=%0d required 0/0", qi.size(), qd.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ram_bus_bridge
`default_nettype wire

// File: doc/ram_bus_bridge.md
# ram_bus_bridge

Two-master front end for the 4096×32 synchronous on-chip RAM: arbitrates the CPU instruction-fetch bus and data bus onto the RAM's single port, decodes the address window, drives the RAM's ADR/D/WEM/WE/ME/OE pins and routes the one-cycle-late RAM read data back to the requesting master. It sits directly upstream of the RAM macro, between the VexRiscv simple-bus ports and the memory.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM word-address width (4096 words).
- BASE_ADDR, 32'h0000_0000, byte base of RAM window; window size 4·2^ADDR_WIDTH bytes, aligned to its size.

Ports (one clock `CLK`; reset `RST` is synchronous, active-high):
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ib_cmd_valid  in  1  fetch request.
- ib_cmd_ready  out  1  fetch accepted this cycle.
- ib_cmd_addr  in  32  fetch byte address.
- ib_rsp_valid  out  1  fetch data valid.
- ib_rsp_data  out  32  fetch data.
- db_cmd_valid  in  1  data request.
- db_cmd_ready  out  1  data accepted this cycle.
- db_cmd_wr  in  1  1 = write, 0 = read.
- db_cmd_addr  in  32  data byte address.
- db_cmd_data  in  32  write data.
- db_cmd_mask  in  4  byte-lane write enables.
- db_rsp_valid  out  1  read data valid (reads only).
- db_rsp_data  out  32  read data.
- oor_pulse  out  1  one-cycle pulse: accepted command outside window.
- RAM_ADR  out  ADDR_WIDTH  RAM word address.
- RAM_D  out  32  RAM write data.
- RAM_WEM  out  4  RAM byte mask.
- RAM_WE  out  1  RAM write enable.
- RAM_ME  out  1  RAM enable.
- RAM_OE  out  1  RAM output enable, constant 1.
- RAM_Q  in  32  RAM read data (valid cycle after ME).

## Operation
- Arbiter states: LAST_I, LAST_D (last grant). Reset → LAST_I.
- Exactly one command accepted per cycle; grant is combinational in the request cycle. Only one valid: it wins. Both valid: master not granted last wins; state updates on every grant.
- Grant: matching cmd_ready = 1, other 0. Ready is 0 whenever that master is not granted; a master must hold valid/addr/data stable until ready.
- In range: addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]. RAM_ADR = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
- In-range grant: RAM_ME = 1; RAM_WE = 1 only for dBus write; RAM_WEM = db_cmd_mask on writes, 4'b0000 otherwise; RAM_D = db_cmd_data.
- Out-of-range grant: RAM_ME = 0, write dropped; oor_pulse = 1 the cycle after acceptance; a read still responds with data 32'h0000_0000.
- No grant: RAM_ME = 0, RAM_WE = 0, RAM_WEM = 0, RAM_ADR/RAM_D hold previous value.
- Response pipeline register {pending, who, oor}: set on every accepted read, cleared otherwise. Next cycle, rsp_valid of `who` = 1; rsp_data = oor ? 0 : RAM_Q. Other master's rsp_valid = 0.
- Writes produce no response. No response backpressure.
- rsp_data of a master with rsp_valid = 0 is don't-care.

## Timing
- Read latency: accept at cycle N → rsp_valid at N+1, single cycle.
- Throughput: one command per cycle, back-to-back reads from either master pipelined without bubbles.
- Write at N then read same word at N+1 returns written data at N+2. Same-word read-during-write cannot occur (single grant per cycle).
- Reset: during any cycle with RST = 1, both cmd_ready = 0, RAM_ME = 0, RAM_WE = 0, RAM_WEM = 0. On the cycle after RST: all rsp_valid = 0, oor_pulse = 0, arbiter = LAST_I, RAM_ADR = 0, RAM_D = 0. A read accepted in the cycle before RST rises gets no response.
- Round-robin bound: with both masters continuously valid, grants strictly alternate.

## Structure
- Package `ram_bus_pkg`: grant enum {GNT_I, GNT_D}, RAM_WORDS, default BASE_ADDR.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with last-grant state register. All other logic lives in the top level.

## Test plan
- Reset: hold RST 3 cycles with both valid = 1 → no ready, RAM_ME = 0. Release → first contention grant goes to dBus.
- Write then read: dBus write 0x0000_0010, data 0xDEADBEEF, mask 4'b0101 over 0x11111111. Then read → db_rsp_data 0x11AD11EF one cycle after acceptance.
- Contention: both valid for 6 cycles, distinct addresses → grants alternate D,I,D,I,D,I. Each rsp routes to the correct master with the correct word.
- Back-to-back iBus fetches 0x0, 0x4, 0x8 → ib_rsp_valid high 3 consecutive cycles, data in order.
- Out of range: dBus write to 0x0001_0000 → RAM_ME = 0, memory unchanged, oor_pulse next cycle. iBus read 0x8000_0000 → data 0, oor_pulse.
- RST asserted the cycle after a read accept → no rsp_valid follows; arbiter back to LAST_I.
